// File: rtl/regfile_2r1w.sv
// rtl/regfile_2r1w.sv - 32-entry register file, two combinational read ports, one write port
// Read ports go through per-bit 32:1 mux trees; a write-first bypass follows each tree.

module mux32 (
  input  logic [31:0] din,
  input  logic [4:0]  sel,
  output logic        dout
);

  assign dout = din[sel];

endmodule

module regfile_2r1w #(
  parameter int WIDTH    = 32,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [4:0]       wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [4:0]       rd_addr0,
  input  logic [4:0]       rd_addr1,
  output logic [WIDTH-1:0] rd_data0,
  output logic [WIDTH-1:0] rd_data1
);

  logic [WIDTH-1:0] regs_q [32];
  logic [WIDTH-1:0] regs_d [32];
  logic [31:0]      wr_dec;
  logic [WIDTH-1:0] tree0;
  logic [WIDTH-1:0] tree1;
  logic             byp0;
  logic             byp1;
  logic             wr_allowed;

  assign wr_allowed = wr_en && !(ZERO_REG && (wr_addr == 5'd0));

  always_comb begin
    wr_dec = '0;
    if (wr_allowed) begin
      wr_dec[wr_addr] = 1'b1;
    end
  end

  always_comb begin
    for (int i = 0; i < 32; i++) begin
      regs_d[i] = regs_q[i];
      if (wr_dec[i]) begin
        regs_d[i] = wr_data;
      end
    end
    // Keeps r0 at zero even before the first reset when it is hardwired.
    if (ZERO_REG) begin
      regs_d[0] = '0;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 32; i++) begin
      if (reset) begin
        regs_q[i] <= '0;
      end else begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // Each bit slice is transposed into a 32-wide column and fed to its own mux pair.
  for (genvar b = 0; b < WIDTH; b++) begin : g_bit
    logic [31:0] col;

    always_comb begin
      for (int i = 0; i < 32; i++) begin
        col[i] = regs_q[i][b];
      end
    end

    mux32 u_mux0 (
      .din  (col),
      .sel  (rd_addr0),
      .dout (tree0[b])
    );

    mux32 u_mux1 (
      .din  (col),
      .sel  (rd_addr1),
      .dout (tree1[b])
    );
  end

  always_comb begin
    byp0 = wr_allowed && !reset && (rd_addr0 == wr_addr);
    byp1 = wr_allowed && !reset && (rd_addr1 == wr_addr);
  end

  always_comb begin
    rd_data0 = byp0 ? wr_data : tree0;
    rd_data1 = byp1 ? wr_data : tree1;
  end

endmodule

// File: tb/tb_regfile_2r1w.sv
// tb/tb_regfile_2r1w.sv - self-checking bench for regfile_2r1w, both ZERO_REG settings
// An array model tracks stored contents; reads are derived from it plus the bypass rule.

module tb_regfile_2r1w;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [4:0]  rd_addr0;
  logic [4:0]  rd_addr1;
  logic [31:0] z_rd0, z_rd1, n_rd0, n_rd1;

  int total = 0;
  int bad   = 0;

  logic [31:0] mz [32];
  logic [31:0] mn [32];
  logic        model_ok = 1'b0;

  always #5 clk = ~clk;

  regfile_2r1w #(.WIDTH(32), .ZERO_REG(1'b1)) dut_z (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_addr0 (rd_addr0),
    .rd_addr1 (rd_addr1),
    .rd_data0 (z_rd0),
    .rd_data1 (z_rd1)
  );

  regfile_2r1w #(.WIDTH(32), .ZERO_REG(1'b0)) dut_n (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_addr0 (rd_addr0),
    .rd_addr1 (rd_addr1),
    .rd_data0 (n_rd0),
    .rd_data1 (n_rd1)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        mz[i] <= 32'h0;
        mn[i] <= 32'h0;
      end
      model_ok <= 1'b1;
    end else if (wr_en) begin
      if (wr_addr != 5'd0) mz[wr_addr] <= wr_data;
      mn[wr_addr] <= wr_data;
    end
  end

  function automatic logic [31:0] exp_rd(input bit zr, input logic [4:0] a);
    if (zr && a == 5'd0) return 32'h0;
    if (wr_en && !reset && a == wr_addr) return wr_data;
    return zr ? mz[a] : mn[a];
  endfunction

  always @(negedge clk) begin
    if (model_ok) begin
      chk("model_z_rd0", z_rd0, exp_rd(1'b1, rd_addr0));
      chk("model_z_rd1", z_rd1, exp_rd(1'b1, rd_addr1));
      chk("model_n_rd0", n_rd0, exp_rd(1'b0, rd_addr0));
      chk("model_n_rd1", n_rd1, exp_rd(1'b0, rd_addr1));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rst, input logic we, input logic [4:0] wa,
                       input logic [31:0] wd, input logic [4:0] a0, input logic [4:0] a1);
    reset    = rst;
    wr_en    = we;
    wr_addr  = wa;
    wr_data  = wd;
    rd_addr0 = a0;
    rd_addr1 = a1;
  endtask

  initial begin
    drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    step();

    // Reset clear
    drive(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd0);
    step();
    drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd0);
    @(negedge clk);
    chk("r5_written", z_rd0, 32'hDEADBEEF);
    #1;
    drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd5, 5'd0);
    step();
    for (int i = 0; i < 32; i++) begin
      drive(1'b0, 1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i));
      @(negedge clk);
      chk("clear_z_rd0", z_rd0, 32'h0);
      chk("clear_n_rd1", n_rd1, 32'h0);
      #1;
    end

    // Write / readback
    drive(1'b0, 1'b1, 5'd1, 32'h11111111, 5'd0, 5'd0);
    step();
    drive(1'b0, 1'b1, 5'd31, 32'hFFFF0000, 5'd0, 5'd0);
    step();
    drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd1, 5'd31);
    @(negedge clk);
    chk("rb_r1", z_rd0, 32'h11111111);
    chk("rb_r31", z_rd1, 32'hFFFF0000);
    #1;
    rd_addr0 = 5'd2;
    @(negedge clk);
    chk("rb_r2_zero", z_rd0, 32'h0);
    #1;

    // Write-first bypass
    drive(1'b0, 1'b1, 5'd7, 32'hAAAA5555, 5'd0, 5'd0);
    step();
    drive(1'b0, 1'b1, 5'd7, 32'h12345678, 5'd7, 5'd7);
    @(negedge clk);
    chk("byp_rd0", z_rd0, 32'h12345678);
    chk("byp_rd1", z_rd1, 32'h12345678);
    step();
    drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd7, 5'd7);
    @(negedge clk);
    chk("byp_stored0", z_rd0, 32'h12345678);
    chk("byp_stored1", z_rd1, 32'h12345678);
    #1;

    // Zero register, both settings
    drive(1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
    @(negedge clk);
    chk("zr1_during", z_rd0, 32'h0);
    chk("zr0_during", n_rd0, 32'hFFFFFFFF);
    step();
    drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    @(negedge clk);
    chk("zr1_after", z_rd0, 32'h0);
    chk("zr0_after", n_rd0, 32'hFFFFFFFF);
    #1;

    // Reset vs write collision
    drive(1'b0, 1'b1, 5'd9, 32'h11112222, 5'd9, 5'd9);
    step();
    drive(1'b1, 1'b1, 5'd9, 32'hCAFEF00D, 5'd9, 5'd9);
    @(negedge clk);
    chk("coll_no_bypass", z_rd0, 32'h11112222);
    step();
    drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd9, 5'd0);
    @(negedge clk);
    chk("coll_r9_cleared", z_rd0, 32'h0);
    chk("coll_r0_n_cleared", n_rd1, 32'h0);
    #1;

    // wr_en low
    drive(1'b0, 1'b0, 5'd3, 32'h00000055, 5'd3, 5'd3);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("wren_low_rd0", z_rd0, 32'h0);
      step();
    end
    @(negedge clk);
    chk("wren_low_after", z_rd0, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
